regbank_dump: RTL and testbench
===============================

// Module: regbank_dump
// PURPOSE
//  Read-side debug engine for REGBANK. On a START pulse it freezes the core,
//  walks READREG addresses 0..NREGS-1 through one REGBANK read port, registers
//  each word and streams {address,data} out on a valid/ready interface (UART
//  TX or bench monitor). Sits beside the core, sharing the read port via a mux.
// PARAMETERS
//  NREGS   32  registers dumped, indices 0..NREGS-1 (2..32)
//  SIZE    32  register data width; must equal REGBANK size
//  ADDR_W  5   register address width; NREGS <= 2**ADDR_W
// PORTS
//  CLK        in   1       clock, all state on rising edge
//  aRSTn      in   1       reset, synchronous, active-low
//  START      in   1       dump request, sampled in IDLE only
//  RD_ADDR    out  ADDR_W  to REGBANK READREG_x (registered)
//  RD_DATA    in   SIZE    from REGBANK read_data_x (combinational read)
//  FREEZE     out  1       stall request to core; blocks REGBANK writes
//  OUT_VALID  out  1       OUT_ADDR/OUT_DATA hold a valid word
//  OUT_READY  in   1       sink accepts word when OUT_VALID & OUT_READY
//  OUT_ADDR   out  ADDR_W  register index of OUT_DATA
//  OUT_DATA   out  SIZE    captured register contents
//  BUSY       out  1       high in every state except IDLE
//  DONE       out  1       one-cycle pulse after last word accepted
// BEHAVIOUR
//  Reset (aRSTn=0 at edge): state IDLE, idx=0; RD_ADDR, OUT_ADDR, OUT_DATA=0;
//   FREEZE, OUT_VALID, BUSY, DONE=0. Applies mid-dump too: dump aborted,
//   no DONE, FREEZE drops at that edge.
//  States: IDLE, LOAD, SEND, FIN. All outputs registered.
//  IDLE: START=1 -> LOAD; idx=0, RD_ADDR=0, FREEZE=1, BUSY=1.
//  LOAD: one cycle for REGBANK read to settle; at edge OUT_DATA<=RD_DATA,
//   OUT_ADDR<=idx, OUT_VALID<=1 -> SEND.
//  SEND: OUT_VALID held; OUT_ADDR/OUT_DATA stable until handshake.
//   Handshake & idx==NREGS-1 -> FIN, OUT_VALID<=0, FREEZE<=0, DONE<=1.
//   Handshake & idx<NREGS-1  -> LOAD, idx++, RD_ADDR<=idx+1, OUT_VALID<=0.
//   No handshake -> stay in SEND.
//  FIN: DONE=1 this cycle only, BUSY=1 -> IDLE (DONE, BUSY <=0).
//  Latency: START at edge t -> first OUT_VALID at edge t+2. With OUT_READY
//   tied high: one word per 2 cycles, DONE high 2*NREGS+1 cycles after START.
//  START while BUSY ignored (not queued); START level held in IDLE after FIN
//   starts a new dump one cycle after DONE.
//  FREEZE high from LOAD entry until FIN entry; core must not write REGBANK
//   while FREEZE=1, so dumped values are one consistent snapshot.
//  idx width ADDR_W; never increments past NREGS-1 (no wrap to 0).
//  OUT_READY ignored when OUT_VALID=0.
// TESTING
//  1 Preload reg[i]=32'hA5A5_0000+i, OUT_READY=1, pulse START -> 32 words
//    OUT_ADDR 0..31 in order, data match, DONE 65 cycles after START, once.
//  2 OUT_READY low 5 cycles while OUT_VALID on word 3 -> OUT_ADDR=3,
//    OUT_DATA=32'hA5A5_0003 stable all 5 cycles, no duplicate or skip after.
//  3 START pulsed at word 10 of a dump -> ignored; exactly 32 words and one
//    DONE produced, BUSY low after FIN.
//  4 aRSTn=0 one cycle at word 7 -> next edge all outputs 0, FREEZE=0,
//    no DONE; fresh START restarts at OUT_ADDR=0.
//  5 Core write to reg 5 attempted during dump -> FREEZE=1 blocks it;
//    dumped reg 5 shows pre-dump value, write lands only after FREEZE=0.
//  6 START held high continuously -> back-to-back dumps, DONE every 66
//    cycles with OUT_READY=1, OUT_ADDR restarting at 0 each time.

Source files
------------

// File: rtl/regbank_dump.sv
// Read-side debug engine: freezes the core, walks every REGBANK register through one
// read port and streams {address, data} words out over a valid/ready interface.
module regbank_dump #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned SIZE   = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              aRSTn,
  input  logic              START,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [SIZE-1:0]   RD_DATA,
  output logic              FREEZE,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [ADDR_W-1:0] OUT_ADDR,
  output logic [SIZE-1:0]   OUT_DATA,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;

  // Dump sequencer; RD_ADDR is registered so LOAD gives the bank a full cycle to settle.
  always_ff @(posedge CLK) begin
    if (!aRSTn) begin
      state     <= IDLE;
      idx       <= '0;
      RD_ADDR   <= '0;
      FREEZE    <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_ADDR  <= '0;
      OUT_DATA  <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state   <= LOAD;
            idx     <= '0;
            RD_ADDR <= '0;
            FREEZE  <= 1'b1;
            BUSY    <= 1'b1;
          end
        end
        LOAD: begin
          OUT_DATA  <= RD_DATA;
          OUT_ADDR  <= idx;
          OUT_VALID <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            if (idx == LAST_IDX) begin
              state  <= FIN;
              FREEZE <= 1'b0;
              DONE   <= 1'b1;
            end else begin
              state   <= LOAD;
              idx     <= idx + ADDR_W'(1);
              RD_ADDR <= idx + ADDR_W'(1);
            end
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_dump.sv
// Directed bench for regbank_dump with a small REGBANK model whose writes are gated by FREEZE.
module tb_regbank_dump;

  localparam int unsigned NREGS  = 32;
  localparam int unsigned SIZE   = 32;
  localparam int unsigned ADDR_W = 5;

  logic              CLK;
  logic              aRSTn;
  logic              START;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [SIZE-1:0]   RD_DATA;
  logic              FREEZE;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [ADDR_W-1:0] OUT_ADDR;
  logic [SIZE-1:0]   OUT_DATA;
  logic              BUSY;
  logic              DONE;

  logic [SIZE-1:0]   regs [0:NREGS-1];
  logic              preload;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [SIZE-1:0]   wr_data;

  int total = 0;
  int bad   = 0;

  regbank_dump #(.NREGS(NREGS), .SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .aRSTn(aRSTn), .START(START), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
    .FREEZE(FREEZE), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_ADDR(OUT_ADDR),
    .OUT_DATA(OUT_DATA), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register bank model: combinational read, core write blocked while FREEZE is high.
  assign RD_DATA = regs[RD_ADDR];
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 32'hA5A5_0000 + 32'(i);
    end else if (wr_req && !FREEZE) begin
      regs[wr_addr] <= wr_data;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SIZE-1:0] expv(input int i, input logic [SIZE-1:0] e5);
    return (i == 5) ? e5 : 32'hA5A5_0000 + 32'(i);
  endfunction

  // Starts a dump (START raised now) and follows it cycle by cycle, checking every word.
  task automatic dump_run(input int stall_w, input int start_w, input bit hold, input bit do_wr,
                          input logic [SIZE-1:0] e5, output int words, output int dones,
                          output int d1, output int d2);
    int cyc;
    int stall;
    bit pulsed;
    int a;
    cyc = 0; stall = 0; pulsed = 0;
    words = 0; dones = 0; d1 = -1; d2 = -1;
    OUT_READY = 1'b1;
    START = 1'b1;
    while (cyc < 400) begin
      tick;
      cyc++;
      if (!hold) START = 1'b0;
      if (do_wr && cyc == 1) begin
        chk("freeze_on_load", 64'(FREEZE), 64'd1);
        wr_req = 1'b1;
      end
      if (DONE) begin
        dones++;
        if (d1 < 0) d1 = cyc; else d2 = cyc;
      end
      if (OUT_VALID) begin
        a = words % NREGS;
        chk("word_addr", 64'(OUT_ADDR), 64'(a));
        chk("word_data", 64'(OUT_DATA), 64'(expv(a, e5)));
        chk("freeze_hold", 64'(FREEZE), 64'd1);
        if (!hold && !pulsed && int'(OUT_ADDR) == start_w) begin
          START = 1'b1;
          pulsed = 1'b1;
        end
        if (int'(OUT_ADDR) == stall_w && stall < 5) begin
          OUT_READY = 1'b0;
          stall++;
        end else begin
          OUT_READY = 1'b1;
          words++;
        end
      end else begin
        OUT_READY = 1'b1;
      end
      if (!hold && dones > 0 && cyc > d1 + 2) break;
      if (hold && dones >= 2) break;
    end
    chk("dump_timeout", 64'(cyc < 400), 64'd1);
    START = 1'b0;
  endtask

  initial begin
    int words, dones, d1, d2, n;
    aRSTn = 1'b0; START = 1'b0; OUT_READY = 1'b0;
    preload = 1'b1; wr_req = 1'b0; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    tick;
    tick;
    preload = 1'b0;
    chk("reset_outputs", {RD_ADDR, OUT_ADDR, OUT_DATA, FREEZE, OUT_VALID, BUSY, DONE}, 64'd0);
    aRSTn = 1'b1;
    tick;
    chk("idle_busy", 64'(BUSY), 64'd0);

    // 1: full dump, sink always ready
    dump_run(-1, -1, 0, 0, 32'hA5A5_0005, words, dones, d1, d2);
    chk("t1_words", 64'(words), 64'd32);
    chk("t1_dones", 64'(dones), 64'd1);
    chk("t1_done_lat", 64'(d1), 64'd65);
    chk("t1_busy_end", 64'(BUSY), 64'd0);

    // 2: back-pressure for 5 cycles on word 3
    dump_run(3, -1, 0, 0, 32'hA5A5_0005, words, dones, d1, d2);
    chk("t2_words", 64'(words), 64'd32);
    chk("t2_dones", 64'(dones), 64'd1);
    chk("t2_done_lat", 64'(d1), 64'd70);

    // 3: START pulsed mid-dump is ignored
    dump_run(-1, 10, 0, 0, 32'hA5A5_0005, words, dones, d1, d2);
    chk("t3_words", 64'(words), 64'd32);
    chk("t3_dones", 64'(dones), 64'd1);
    chk("t3_done_lat", 64'(d1), 64'd65);
    chk("t3_busy_end", 64'(BUSY), 64'd0);
    tick;
    tick;
    chk("t3_no_restart", {BUSY, FREEZE, OUT_VALID}, 64'd0);

    // 4: reset at word 7 aborts the dump
    START = 1'b1; OUT_READY = 1'b1;
    tick;
    START = 1'b0;
    n = 0;
    while (!(OUT_VALID && OUT_ADDR == 5'd7) && n < 100) begin
      tick;
      n++;
    end
    chk("t4_reach_word7", 64'(n < 100), 64'd1);
    aRSTn = 1'b0;
    tick;
    aRSTn = 1'b1;
    chk("t4_reset_outputs", {RD_ADDR, OUT_ADDR, OUT_DATA, FREEZE, OUT_VALID, BUSY, DONE}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t4_quiet", {BUSY, DONE, OUT_VALID}, 64'd0);
    end
    dump_run(-1, -1, 0, 0, 32'hA5A5_0005, words, dones, d1, d2);
    chk("t4_words", 64'(words), 64'd32);
    chk("t4_done_lat", 64'(d1), 64'd65);

    // 5: core write to reg 5 held off by FREEZE until the dump ends
    dump_run(-1, -1, 0, 1, 32'hA5A5_0005, words, dones, d1, d2);
    chk("t5_words", 64'(words), 64'd32);
    chk("t5_reg5_after", 64'(regs[5]), 64'h0000_0000_DEAD_BEEF);
    wr_req = 1'b0;
    tick;

    // 6: START held high gives back-to-back dumps
    dump_run(-1, -1, 1, 0, 32'hDEAD_BEEF, words, dones, d1, d2);
    chk("t6_words", 64'(words), 64'd64);
    chk("t6_first_done", 64'(d1), 64'd65);
    chk("t6_period", 64'(d2 - d1), 64'd66);
    n = 0;
    while (BUSY && n < 200) begin
      tick;
      n++;
    end
    chk("t6_settle", 64'(n < 200), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
